uart_rx_fifo_monitor: RTL

Synthesizable, parametrised UART receiver with a receive FIFO. It generalises the fixed 8N1 receive path used on the SoC UART bus to configurable data bits, parity and stop bits, with per-byte error tagging. It sits between the chip-level in_uart_rx pin and an on-chip consumer, for example a test-status logger or debug bridge, that drains bytes through a valid/ready handshake.

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/uart_rx_fifo_monitor.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the parametrised UART receiver and its receive FIFO.
package uart_rx_pkg;

    localparam int MAX_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    typedef struct packed {
        logic                     parity_err;
        logic [MAX_DATA_BITS-1:0] data;
    } fifo_entry_t;

    function automatic int calc_div(input int clk_freq_hz, input int baud_rate);
        return clk_freq_hz / baud_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full succeeds only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (PTR_W + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is masked while empty so the output reads 0 out of reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // NOTE: the storage array has no reset; valid data is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo_monitor.sv
// UART receiver (configurable data/parity/stop bits) feeding a tagged receive FIFO
// with sticky framing and overrun flags.
module uart_rx_fifo_monitor
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25000000,
    parameter int BAUD_RATE   = 781250,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                        in_clk,
    input  logic                        in_rst,
    input  logic                        in_uart_rx,
    output logic [DATA_BITS-1:0]        out_data,
    output logic                        out_parity_err,
    output logic                        out_valid,
    input  logic                        in_ready,
    output logic [$clog2(FIFO_DEPTH):0] out_level,
    output logic                        out_frame_err,
    output logic                        out_overrun,
    input  logic                        in_clr_err,
    output logic                        out_busy
);

    localparam int   DIV     = calc_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int   CNT_W   = $clog2(DIV);
    localparam logic ODD_BIT = (PARITY_ODD != 0);

    rx_state_t            state;
    rx_state_t            next_state;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_d;
    logic                 start_edge;
    logic [CNT_W-1:0]     baud_cnt;
    logic                 sample;
    logic [2:0]           bit_cnt;
    logic                 last_data;
    logic                 last_stop;
    logic [DATA_BITS-1:0] data_sr;
    logic                 parity_err;
    logic                 push;
    logic                 stop_low;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    fifo_entry_t          wr_entry;
    logic [DATA_BITS:0]   head;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= in_uart_rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign start_edge = rx_d && !rx_s;

    // Held at 0 in IDLE so every start edge begins a fresh bit period.
    always_ff @(posedge in_clk) begin
        if (in_rst || state == IDLE || baud_cnt == CNT_W'(DIV - 1)) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    assign sample    = (state != IDLE) && (baud_cnt == CNT_W'(DIV / 2));
    assign last_data = (bit_cnt == 3'(DATA_BITS - 1));
    assign last_stop = (bit_cnt == 3'(STOP_BITS - 1));

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_edge) next_state = START;
            START:   if (sample) next_state = rx_s ? IDLE : DATA;
            DATA:    if (sample && last_data) next_state = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (sample) next_state = STOP;
            STOP:    if (sample && last_stop) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        push     = 1'b0;
        stop_low = 1'b0;
        out_busy = (state != IDLE);
        if (state == STOP && sample) begin
            push     = last_stop;
            stop_low = !rx_s;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            bit_cnt    <= '0;
            data_sr    <= '0;
            parity_err <= 1'b0;
        end else if (sample) begin
            case (state)
                START: begin
                    bit_cnt    <= '0;
                    parity_err <= 1'b0;
                end
                DATA: begin
                    data_sr <= {rx_s, data_sr[DATA_BITS-1:1]};
                    bit_cnt <= last_data ? 3'd0 : bit_cnt + 1'b1;
                end
                PARITY:  parity_err <= (^data_sr) ^ rx_s ^ ODD_BIT;
                STOP:    bit_cnt <= last_stop ? 3'd0 : bit_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign wr_entry = '{parity_err: parity_err, data: MAX_DATA_BITS'(data_sr)};
    assign pop      = out_valid && in_ready;

    sync_fifo #(
        .WIDTH (DATA_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (in_clk),
        .rst     (in_rst),
        .push    (push),
        .pop     (pop),
        .wr_data ({wr_entry.parity_err, wr_entry.data[DATA_BITS-1:0]}),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (out_level)
    );

    assign out_valid      = !fifo_empty;
    assign out_data       = head[DATA_BITS-1:0];
    assign out_parity_err = head[DATA_BITS];

    // Setting wins over a simultaneous clear so no event is ever lost.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_frame_err <= 1'b0;
            out_overrun   <= 1'b0;
        end else begin
            if (stop_low)        out_frame_err <= 1'b1;
            else if (in_clr_err) out_frame_err <= 1'b0;
            if (push && fifo_full && !pop) out_overrun <= 1'b1;
            else if (in_clr_err)           out_overrun <= 1'b0;
        end
    end

endmodule
